// File: rtl/cmd_rx_core.sv
// Receive end of the command sequencer serial link: sync-word hunt, NRZ/Manchester decode,
// MSB-first deserialization and a valid/ready byte stream with frame and error counters.
module cmd_rx_core #(
   parameter int unsigned           SYNC_WIDTH   = 8,
   parameter logic [SYNC_WIDTH-1:0] SYNC_PATTERN = 8'hB2
) (
   input  logic        CMD_CLK_IN,
   input  logic        CMD_RST_N,
   input  logic        CMD_DATA_IN,
   input  logic        CONF_EN,
   input  logic [1:0]  CONF_MODE,
   input  logic [15:0] CONF_FRAME_BITS,
   input  logic        CLR_CNT,
   input  logic        DATA_READY,
   output logic [7:0]  DATA_OUT,
   output logic        DATA_VALID,
   output logic        DATA_LAST,
   output logic        FRAME_START,
   output logic        BUSY,
   output logic        CODE_ERR,
   output logic        OVERFLOW,
   output logic [15:0] FRAME_CNT,
   output logic [7:0]  ERR_CNT
);

   localparam int unsigned RAW_W = 2 * SYNC_WIDTH;

   // Sync word as it appears in the raw half-bit sample stream, first half in the higher bit.
   function automatic logic [RAW_W-1:0] expand_sync(input logic [SYNC_WIDTH-1:0] pat,
                                                    input logic                  thomas);
      logic [RAW_W-1:0] res;
      res = '0;
      for (int unsigned i = 0; i < SYNC_WIDTH; i++) begin
         res[2*i+1] = thomas ? pat[i] : ~pat[i];
         res[2*i]   = thomas ? ~pat[i] : pat[i];
      end
      return res;
   endfunction

   localparam logic [RAW_W-1:0] SYNC_IEEE   = expand_sync(SYNC_PATTERN, 1'b0);
   localparam logic [RAW_W-1:0] SYNC_THOMAS = expand_sync(SYNC_PATTERN, 1'b1);

   typedef enum logic [0:0] {StHunt, StRecv} state_e;

   logic             r_sync1, r_sync2;
   state_e           r_state;
   logic [RAW_W-1:0] r_hunt;
   logic [1:0]       r_mode;
   logic [15:0]      r_frame_bits;
   logic [15:0]      r_bit_cnt;
   logic [7:0]       r_byte;
   logic             r_half;
   logic             r_first;
   logic [7:0]       r_data;
   logic             r_valid;
   logic             r_last;
   logic             r_frame_start;
   logic             r_code_err;
   logic             r_overflow;
   logic [15:0]      r_frame_cnt;
   logic [7:0]       r_err_cnt;

   logic             w_s;
   logic [RAW_W-1:0] w_hunt_nxt;
   logic             w_match;
   logic             w_sync_hit;
   logic             w_manch;
   logic             w_recv_act;
   logic             w_viol;
   logic             w_bit_vld;
   logic             w_bit;
   logic [7:0]       w_byte_nxt;
   logic             w_last;
   logic             w_done;
   logic [2:0]       w_shift;
   logic [7:0]       w_out;
   logic             w_accept;

   always_ff @(posedge CMD_CLK_IN or negedge CMD_RST_N) begin
      if (!CMD_RST_N) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= CMD_DATA_IN;
         r_sync2 <= r_sync1;
      end
   end

   assign w_s        = r_sync2;
   assign w_hunt_nxt = {r_hunt[RAW_W-2:0], w_s};

   always_comb begin
      w_match = 1'b0;
      if (!CONF_MODE[1]) begin
         w_match = (w_hunt_nxt[SYNC_WIDTH-1:0] == SYNC_PATTERN);
      end else if (CONF_MODE[0]) begin
         w_match = (w_hunt_nxt == SYNC_THOMAS);
      end else begin
         w_match = (w_hunt_nxt == SYNC_IEEE);
      end
   end

   assign w_sync_hit = CONF_EN && (r_state == StHunt) && w_match && (CONF_FRAME_BITS != 16'd0);

   // Manchester bits resolve on the second half; the first half is parked in r_first.
   assign w_manch    = r_mode[1];
   assign w_recv_act = CONF_EN && (r_state == StRecv) && (!w_manch || r_half);
   assign w_viol     = w_recv_act && w_manch && (w_s == r_first);
   assign w_bit_vld  = w_recv_act && !w_viol;
   assign w_bit      = (w_manch && r_mode[0]) ? r_first : w_s;
   assign w_byte_nxt = {r_byte[6:0], w_bit};
   assign w_last     = (r_bit_cnt == (r_frame_bits - 16'd1));
   assign w_done     = w_bit_vld && ((r_bit_cnt[2:0] == 3'd7) || w_last);
   assign w_shift    = 3'd7 - r_bit_cnt[2:0];
   assign w_out      = w_byte_nxt << w_shift;
   assign w_accept   = !r_valid || DATA_READY;

   always_ff @(posedge CMD_CLK_IN or negedge CMD_RST_N) begin
      if (!CMD_RST_N) begin
         r_state       <= StHunt;
         r_hunt        <= '0;
         r_mode        <= 2'd0;
         r_frame_bits  <= 16'd0;
         r_bit_cnt     <= 16'd0;
         r_byte        <= 8'd0;
         r_half        <= 1'b0;
         r_first       <= 1'b0;
         r_data        <= 8'd0;
         r_valid       <= 1'b0;
         r_last        <= 1'b0;
         r_frame_start <= 1'b0;
         r_code_err    <= 1'b0;
         r_overflow    <= 1'b0;
         r_frame_cnt   <= 16'd0;
         r_err_cnt     <= 8'd0;
      end else begin
         r_frame_start <= 1'b0;
         r_code_err    <= 1'b0;

         if (r_valid && DATA_READY) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
         end
         if (w_done) begin
            if (w_accept) begin
               r_data  <= w_out;
               r_valid <= 1'b1;
               r_last  <= w_last;
            end else begin
               r_overflow <= 1'b1;
            end
         end

         unique case (r_state)
            StHunt: begin
               if (!CONF_EN) begin
                  r_hunt <= '0;
               end else if (w_sync_hit) begin
                  r_hunt        <= '0;
                  r_mode        <= CONF_MODE;
                  r_frame_bits  <= CONF_FRAME_BITS;
                  r_frame_start <= 1'b1;
                  r_bit_cnt     <= 16'd0;
                  r_byte        <= 8'd0;
                  r_half        <= 1'b0;
                  r_state       <= StRecv;
               end else begin
                  r_hunt <= w_hunt_nxt;
               end
            end
            StRecv: begin
               if (!CONF_EN) begin
                  r_state <= StHunt;
               end else if (w_manch && !r_half) begin
                  r_first <= w_s;
                  r_half  <= 1'b1;
               end else begin
                  r_half <= 1'b0;
                  if (w_viol) begin
                     r_state    <= StHunt;
                     r_code_err <= 1'b1;
                     if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 16'd1;
                     r_byte    <= w_done ? 8'd0 : w_byte_nxt;
                     if (w_done && w_last) begin
                        r_state     <= StHunt;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                     end
                  end
               end
            end
            default: r_state <= StHunt;
         endcase

         if (CLR_CNT) begin
            r_frame_cnt <= 16'd0;
            r_err_cnt   <= 8'd0;
            r_overflow  <= 1'b0;
         end
      end
   end

   assign DATA_OUT    = r_data;
   assign DATA_VALID  = r_valid;
   assign DATA_LAST   = r_last;
   assign FRAME_START = r_frame_start;
   assign BUSY        = (r_state == StRecv);
   assign CODE_ERR    = r_code_err;
   assign OVERFLOW    = r_overflow;
   assign FRAME_CNT   = r_frame_cnt;
   assign ERR_CNT     = r_err_cnt;

endmodule

// File: tb/tb_cmd_rx_core.sv
// Bench for cmd_rx_core: byte scoreboard checked on every accepted transfer, plus per-scenario
// checks of counters, pulses, backpressure and asynchronous reset.
module tb_cmd_rx_core;

   logic        clk;
   logic        rst_n;
   logic        din;
   logic        en;
   logic [1:0]  mode;
   logic [15:0] fbits;
   logic        clr;
   logic        ready;
   logic [7:0]  dout;
   logic        dvalid;
   logic        dlast;
   logic        fstart;
   logic        busy;
   logic        cerr;
   logic        ovf;
   logic [15:0] fcnt;
   logic [7:0]  ecnt;

   int          n_vec;
   int          n_err;
   int          fs_cnt;
   int          ce_cnt;
   logic [8:0]  exp_q[$];
   logic [8:0]  exp_item;

   cmd_rx_core dut (
      .CMD_CLK_IN      (clk),
      .CMD_RST_N       (rst_n),
      .CMD_DATA_IN     (din),
      .CONF_EN         (en),
      .CONF_MODE       (mode),
      .CONF_FRAME_BITS (fbits),
      .CLR_CNT         (clr),
      .DATA_READY      (ready),
      .DATA_OUT        (dout),
      .DATA_VALID      (dvalid),
      .DATA_LAST       (dlast),
      .FRAME_START     (fstart),
      .BUSY            (busy),
      .CODE_ERR        (cerr),
      .OVERFLOW        (ovf),
      .FRAME_CNT       (fcnt),
      .ERR_CNT         (ecnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: every accepted byte is popped and compared against {last, data}.
   always @(negedge clk) begin
      if (rst_n) begin
         if (fstart) fs_cnt++;
         if (cerr) ce_cnt++;
         if (dvalid && ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL byte_unexpected: got data %h last %b, none expected", dout, dlast);
            end else begin
               exp_item = exp_q.pop_front();
               if ({dlast, dout} !== exp_item) begin
                  n_err++;
                  $display("FAIL byte_stream: got last %b data %h, want last %b data %h",
                           dlast, dout, exp_item[8], exp_item[7:0]);
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tx(input logic b);
      @(posedge clk);
      #1;
      din = b;
   endtask

   task automatic tx_bit(input logic b);
      if (mode[1]) begin
         tx(mode[0] ? b : ~b);
         tx(mode[0] ? ~b : b);
      end else begin
         tx(b);
      end
   endtask

   task automatic tx_bits(input logic [15:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) tx_bit(v[i]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tx(1'b0);
   endtask

   task automatic push(input logic [7:0] d, input logic last);
      exp_q.push_back({last, d});
   endtask

   task automatic drain();
      for (int k = 0; k < 80 && exp_q.size() != 0; k++) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; din = 1'b0; en = 1'b1; mode = 2'd0; fbits = 16'd16;
      clr = 1'b0; ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if ({dout, dvalid, dlast, fstart, busy, cerr, ovf} !== 14'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got %h, want 0",
                  {dout, dvalid, dlast, fstart, busy, cerr, ovf});
      end
      n_vec++;
      if ({fcnt, ecnt} !== 24'd0) begin
         n_err++;
         $display("FAIL reset_counters: got %h, want 0", {fcnt, ecnt});
      end
      rst_n = 1'b1;
      idle(3);
      n_vec++;
      if ({dvalid, busy, fstart} !== 3'd0) begin
         n_err++;
         $display("FAIL idle_after_reset: got %b, want 000", {dvalid, busy, fstart});
      end
   endtask

   task automatic test_nrz_basic();
      int fs0;
      fs0 = fs_cnt;
      mode = 2'd0; fbits = 16'd16;
      idle(4);
      push(8'hA5, 1'b0);
      push(8'h3C, 1'b1);
      tx_bits(16'h00B2, 8);
      tx_bits(16'h00A5, 8);
      tx_bits(16'h003C, 8);
      idle(4);
      drain();
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL nrz_basic_drain: got %0d pending, want 0", exp_q.size());
      end
      n_vec++;
      if (fs_cnt - fs0 != 1) begin
         n_err++;
         $display("FAIL nrz_basic_fstart: got %0d pulses, want 1", fs_cnt - fs0);
      end
      n_vec++;
      if (fcnt !== 16'd1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL nrz_basic_fcnt: got cnt %0d busy %b, want 1 0", fcnt, busy);
      end
   endtask

   task automatic test_partial_byte();
      int fs0;
      fs0 = fs_cnt;
      mode = 2'd1; fbits = 16'd12;
      idle(3);
      push(8'hAF, 1'b0);
      push(8'h10, 1'b1);
      tx_bits(16'h00B2, 8);
      tx_bits(16'h0AF1, 12);
      idle(3);
      push(8'h3C, 1'b0);
      push(8'h50, 1'b1);
      tx_bits(16'h00B2, 8);
      tx_bits(16'h03C5, 12);
      idle(4);
      drain();
      n_vec++;
      if (exp_q.size() != 0 || fs_cnt - fs0 != 2) begin
         n_err++;
         $display("FAIL partial_frames: got pending %0d pulses %0d, want 0 2",
                  exp_q.size(), fs_cnt - fs0);
      end
      n_vec++;
      if (fcnt !== 16'd3) begin
         n_err++;
         $display("FAIL partial_fcnt: got %0d, want 3", fcnt);
      end
   endtask

   task automatic test_manchester();
      int ce0;
      int fs0;
      ce0 = ce_cnt;
      fs0 = fs_cnt;
      for (int m = 2; m <= 3; m++) begin
         mode = 2'(m); fbits = 16'd8;
         idle(7);
         push(8'h5A, 1'b1);
         tx_bits(16'h00B2, 8);
         tx_bits(16'h005A, 8);
         idle(6);
         drain();
         n_vec++;
         if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL manch_mode%0d_byte: got %0d pending, want 0", m, exp_q.size());
         end
      end
      n_vec++;
      if (ce_cnt - ce0 != 0 || fs_cnt - fs0 != 2) begin
         n_err++;
         $display("FAIL manch_flags: got code_err %0d fstart %0d, want 0 2",
                  ce_cnt - ce0, fs_cnt - fs0);
      end
      n_vec++;
      if (fcnt !== 16'd5) begin
         n_err++;
         $display("FAIL manch_fcnt: got %0d, want 5", fcnt);
      end
   endtask

   task automatic test_code_violation();
      int ce0;
      ce0 = ce_cnt;
      mode = 2'd2; fbits = 16'd16;
      idle(5);
      tx_bits(16'h00B2, 8);
      tx_bits(16'h0016, 5);
      tx(1'b0);
      tx(1'b0);
      idle(10);
      n_vec++;
      if (ce_cnt - ce0 != 1) begin
         n_err++;
         $display("FAIL violation_pulse: got %0d cycles, want 1", ce_cnt - ce0);
      end
      n_vec++;
      if (ecnt !== 8'd1 || fcnt !== 16'd5 || busy !== 1'b0 || dvalid !== 1'b0) begin
         n_err++;
         $display("FAIL violation_state: got ecnt %0d fcnt %0d busy %b valid %b, want 1 5 0 0",
                  ecnt, fcnt, busy, dvalid);
      end
      push(8'h12, 1'b0);
      push(8'h34, 1'b1);
      tx_bits(16'h00B2, 8);
      tx_bits(16'h1234, 16);
      idle(6);
      drain();
      n_vec++;
      if (exp_q.size() != 0 || fcnt !== 16'd6) begin
         n_err++;
         $display("FAIL violation_recover: got pending %0d fcnt %0d, want 0 6",
                  exp_q.size(), fcnt);
      end
   endtask

   task automatic test_backpressure();
      logic [23:0] payload;
      payload = 24'h112233;
      mode = 2'd0; fbits = 16'd24;
      idle(3);
      push(8'h11, 1'b0);
      push(8'h33, 1'b1);
      tx_bits(16'h00B2, 8);
      ready = 1'b0;
      for (int i = 0; i < 24; i++) begin
         if (i == 21) begin
            n_vec++;
            if (dvalid !== 1'b1 || dout !== 8'h11 || ovf !== 1'b1) begin
               n_err++;
               $display("FAIL bp_held: got valid %b data %h ovf %b, want 1 11 1",
                        dvalid, dout, ovf);
            end
            ready = 1'b1;
         end
         tx_bit(payload[23-i]);
      end
      idle(6);
      drain();
      n_vec++;
      if (exp_q.size() != 0 || ovf !== 1'b1 || fcnt !== 16'd7) begin
         n_err++;
         $display("FAIL bp_after: got pending %0d ovf %b fcnt %0d, want 0 1 7",
                  exp_q.size(), ovf, fcnt);
      end
      @(posedge clk); #1; clr = 1'b1;
      @(posedge clk); #1; clr = 1'b0;
      n_vec++;
      if (fcnt !== 16'd0 || ecnt !== 8'd0 || ovf !== 1'b0) begin
         n_err++;
         $display("FAIL clr_cnt: got fcnt %0d ecnt %0d ovf %b, want 0 0 0", fcnt, ecnt, ovf);
      end
   endtask

   task automatic test_async_reset();
      mode = 2'd0; fbits = 16'd16;
      idle(3);
      push(8'hDE, 1'b0);
      push(8'hAD, 1'b1);
      tx_bits(16'h00B2, 8);
      tx_bits(16'hDEAD, 16);
      idle(5);
      drain();
      tx_bits(16'h00B2, 8);
      tx_bits(16'h01BD, 9);
      tx(1'b1);
      n_vec++;
      if (busy !== 1'b1 || fcnt !== 16'd1) begin
         n_err++;
         $display("FAIL pre_reset: got busy %b fcnt %0d, want 1 1", busy, fcnt);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({dout, dvalid, dlast, fstart, busy, cerr, ovf, fcnt, ecnt} !== 38'd0) begin
         n_err++;
         $display("FAIL async_reset: got %h, want 0",
                  {dout, dvalid, dlast, fstart, busy, cerr, ovf, fcnt, ecnt});
      end
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(3);
      push(8'h77, 1'b0);
      push(8'h88, 1'b1);
      tx_bits(16'h00B2, 8);
      tx_bits(16'h7788, 16);
      idle(5);
      drain();
      n_vec++;
      if (exp_q.size() != 0 || fcnt !== 16'd1) begin
         n_err++;
         $display("FAIL post_reset_frame: got pending %0d fcnt %0d, want 0 1",
                  exp_q.size(), fcnt);
      end
   endtask

   initial begin
      n_vec = 0; n_err = 0; fs_cnt = 0; ce_cnt = 0;
      test_reset();
      test_nrz_basic();
      test_partial_byte();
      test_manchester();
      test_code_violation();
      test_backpressure();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
